// File: rtl/data_mem_pkg.sv
// Shared sizes and types for the processor data memory.
package data_mem_pkg;

    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/data_mem_wr_prio.sv
// Write-port priority resolver: a port's write survives only if no higher-numbered
// enabled port targets the same address, so at most one survivor exists per address.
module data_mem_wr_prio
    import data_mem_pkg::*;
(
    input  addr_t                wr_addr [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] wr_en,
    output logic [NUM_PORTS-1:0] wr_commit_c
);

    always_comb begin
        wr_commit_c = wr_en;
        for (int unsigned p = 0; p < NUM_PORTS - 1; p++) begin
            for (int unsigned q = p + 1; q < NUM_PORTS; q++) begin
                if (wr_en[PORT_W'(q)] && (wr_addr[PORT_W'(q)] == wr_addr[PORT_W'(p)])) begin
                    wr_commit_c[PORT_W'(p)] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/data_memory.sv
// 512 x 32 data memory: four combinational read ports, four prioritised write ports.
// Define DATA_MEM_BYPASS_EN to forward same-cycle write data onto matching reads.
module data_memory
    import data_mem_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  addr_t data_rd1,
    input  addr_t data_rd2,
    input  addr_t data_rd3,
    input  addr_t data_rd4,
    input  addr_t data_wr1,
    input  addr_t data_wr2,
    input  addr_t data_wr3,
    input  addr_t data_wr4,
    input  word_t data_wr1_data,
    input  word_t data_wr2_data,
    input  word_t data_wr3_data,
    input  word_t data_wr4_data,
    input  logic  data_wr1_enable,
    input  logic  data_wr2_enable,
    input  logic  data_wr3_enable,
    input  logic  data_wr4_enable,
    output word_t data_rd1_out,
    output word_t data_rd2_out,
    output word_t data_rd3_out,
    output word_t data_rd4_out
);

    word_t                mem [DEPTH];
    addr_t                rd_addr [NUM_PORTS];
    addr_t                wr_addr [NUM_PORTS];
    word_t                wr_data [NUM_PORTS];
    word_t                rd_word [NUM_PORTS];
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] wr_commit;

    assign rd_addr[0] = data_rd1;
    assign rd_addr[1] = data_rd2;
    assign rd_addr[2] = data_rd3;
    assign rd_addr[3] = data_rd4;
    assign wr_addr[0] = data_wr1;
    assign wr_addr[1] = data_wr2;
    assign wr_addr[2] = data_wr3;
    assign wr_addr[3] = data_wr4;
    assign wr_data[0] = data_wr1_data;
    assign wr_data[1] = data_wr2_data;
    assign wr_data[2] = data_wr3_data;
    assign wr_data[3] = data_wr4_data;
    assign wr_en      = {data_wr4_enable, data_wr3_enable, data_wr2_enable, data_wr1_enable};

    data_mem_wr_prio u_wr_prio (
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .wr_commit_c (wr_commit)
    );

    // Surviving writes never share an address, so commit order is irrelevant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (wr_commit[PORT_W'(p)] == 1'b1) begin
                    mem[wr_addr[PORT_W'(p)]] <= wr_data[PORT_W'(p)];
                end
            end
        end
    end

    // Read muxes; reset forces zero in every build.
    always_comb begin
        for (int unsigned r = 0; r < NUM_PORTS; r++) begin
            rd_word[PORT_W'(r)] = mem[rd_addr[PORT_W'(r)]];
`ifdef DATA_MEM_BYPASS_EN
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (wr_commit[PORT_W'(p)] && (wr_addr[PORT_W'(p)] == rd_addr[PORT_W'(r)])) begin
                    rd_word[PORT_W'(r)] = wr_data[PORT_W'(p)];
                end
            end
`endif
            if (reset) begin
                rd_word[PORT_W'(r)] = '0;
            end
        end
    end

    assign data_rd1_out = rd_word[0];
    assign data_rd2_out = rd_word[1];
    assign data_rd3_out = rd_word[2];
    assign data_rd4_out = rd_word[3];

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory; honours DATA_MEM_BYPASS_EN for the read-during-write step.
module tb_data_memory;
    import data_mem_pkg::*;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    addr_t rd1 = '0, rd2 = '0, rd3 = '0, rd4 = '0;
    addr_t wr1 = '0, wr2 = '0, wr3 = '0, wr4 = '0;
    word_t wd1 = '0, wd2 = '0, wd3 = '0, wd4 = '0;
    logic  we1 = 1'b0, we2 = 1'b0, we3 = 1'b0, we4 = 1'b0;
    word_t ro1, ro2, ro3, ro4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    data_memory dut (
        .clock            (clock),
        .reset            (reset),
        .data_rd1         (rd1),
        .data_rd2         (rd2),
        .data_rd3         (rd3),
        .data_rd4         (rd4),
        .data_wr1         (wr1),
        .data_wr2         (wr2),
        .data_wr3         (wr3),
        .data_wr4         (wr4),
        .data_wr1_data    (wd1),
        .data_wr2_data    (wd2),
        .data_wr3_data    (wd3),
        .data_wr4_data    (wd4),
        .data_wr1_enable  (we1),
        .data_wr2_enable  (we2),
        .data_wr3_enable  (we3),
        .data_wr4_enable  (we4),
        .data_rd1_out     (ro1),
        .data_rd2_out     (ro2),
        .data_rd3_out     (ro3),
        .data_rd4_out     (ro4)
    );

    task automatic check(input string tag, input word_t observed, input word_t expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Step one clock, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic no_writes();
        we1 = 1'b0; we2 = 1'b0; we3 = 1'b0; we4 = 1'b0;
    endtask

    initial begin
        // 1: reset, then sample corner addresses
        rd1 = 9'd0; rd2 = 9'd1; rd3 = 9'd255; rd4 = 9'd511;
        tick();
        tick();
        check("rst_hold_rd1", ro1, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_a0",   ro1, 32'h0);
        check("rst_a1",   ro2, 32'h0);
        check("rst_a255", ro3, 32'h0);
        check("rst_a511", ro4, 32'h0);

        // 2: single write
        wr1 = 9'd5; wd1 = 32'hDEADBEEF; we1 = 1'b1;
        tick();
        no_writes();
        rd1 = 9'd5; rd2 = 9'd6;
        #1;
        check("single_a5", ro1, 32'hDEADBEEF);
        check("single_a6", ro2, 32'h0);

        // 3: four parallel writes to distinct addresses
        wr1 = 9'd10; wd1 = 32'h11; we1 = 1'b1;
        wr2 = 9'd11; wd2 = 32'h22; we2 = 1'b1;
        wr3 = 9'd12; wd3 = 32'h33; we3 = 1'b1;
        wr4 = 9'd13; wd4 = 32'h44; we4 = 1'b1;
        tick();
        no_writes();
        rd1 = 9'd10; rd2 = 9'd11; rd3 = 9'd12; rd4 = 9'd13;
        #1;
        check("par_a10", ro1, 32'h11);
        check("par_a11", ro2, 32'h22);
        check("par_a12", ro3, 32'h33);
        check("par_a13", ro4, 32'h44);

        // 4: collisions, highest port wins
        wr1 = 9'd20; wd1 = 32'hAAAA0000; we1 = 1'b1;
        wr4 = 9'd20; wd4 = 32'h0000BBBB; we4 = 1'b1;
        tick();
        no_writes();
        rd1 = 9'd20; rd2 = 9'd5;
        #1;
        check("coll_w1w4", ro1, 32'h0000BBBB);
        check("coll_other", ro2, 32'hDEADBEEF);
        wr2 = 9'd20; wd2 = 32'h22222222; we2 = 1'b1;
        wr3 = 9'd20; wd3 = 32'h33333333; we3 = 1'b1;
        tick();
        no_writes();
        #1;
        check("coll_w2w3", ro1, 32'h33333333);

        // 5: read during write
        wr1 = 9'd30; wd1 = 32'd7; we1 = 1'b1;
        tick();
        wd1 = 32'd9;
        rd1 = 9'd30; rd2 = 9'd30;
        #1;
`ifdef DATA_MEM_BYPASS_EN
        check("rdw_before", ro1, 32'd9);
`else
        check("rdw_before", ro1, 32'd7);
`endif
        tick();
        no_writes();
        #1;
        check("rdw_after", ro2, 32'd9);
        wr2 = 9'd30; wd2 = 32'hFFFF; we2 = 1'b0;
        tick();
        check("en0_nochange", ro1, 32'd9);

        // 6: async reset between edges
        wr1 = 9'd40; wd1 = 32'h1234; we1 = 1'b1;
        tick();
        no_writes();
        rd1 = 9'd40; rd2 = 9'd5; rd3 = 9'd41;
        #1;
        check("pre_rst_a40", ro1, 32'h1234);
        #2;
        reset = 1'b1;
        #1;
        check("async_a40", ro1, 32'h0);
        check("async_a5",  ro2, 32'h0);
        wr1 = 9'd41; wd1 = 32'h55; we1 = 1'b1;
        tick();
        no_writes();
        reset = 1'b0;
        #1;
        check("post_rst_a41", ro3, 32'h0);
        check("post_rst_a40", ro1, 32'h0);
        check("post_rst_a5",  ro2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
